// File: rtl/ballot_collector.sv
// Ballot collector: gathers one 2-bit ballot per voter over valid/ready and holds an 8-bit frame for the tally.
// Optional timeout force-emit is built only when BALLOT_TIMEOUT_EN is defined.
module ballot_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [1:0]  DEFAULT_BALLOT = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_voter,
  input  logic [1:0] in_ballot,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic [7:0] frame_data,
  output logic [3:0] frame_mask,
  output logic       dup_err,
  output logic       timeout_flag
);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] mask_q, mask_d;
  logic       dup_err_q, dup_err_d;
  logic       timeout_flag_q, timeout_flag_d;
  logic       accept;

`ifdef BALLOT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`else
  logic       unused_params;
  assign unused_params = ^{TIMEOUT_CYCLES[7:0], DEFAULT_BALLOT};
`endif

  assign accept = in_valid && (state_q == COLLECT);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= COLLECT;
      data_q         <= '0;
      mask_q         <= '0;
      dup_err_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      dup_err_q      <= dup_err_d;
      timeout_flag_q <= timeout_flag_d;
`ifdef BALLOT_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    mask_d         = mask_q;
    dup_err_d      = 1'b0;
    timeout_flag_d = timeout_flag_q;
`ifdef BALLOT_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          // A repeat voter is consumed but dropped; the first ballot stands.
          if (mask_q[in_voter]) begin
            dup_err_d = 1'b1;
          end else begin
            data_d[{in_voter, 1'b0} +: 2] = in_ballot;
            mask_d[in_voter]              = 1'b1;
          end
        end
`ifdef BALLOT_TIMEOUT_EN
        if (mask_q != 4'b0000) begin
          cnt_d = cnt_q + 8'd1;
        end else if (accept) begin
          cnt_d = 8'd1;
        end
`endif
        if (mask_d == 4'b1111) begin
          state_d = EMIT;
`ifdef BALLOT_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYCLES[7:0]) begin
          // A full frame on this edge takes priority over the timeout fill above.
          for (int k = 0; k < 4; k++) begin
            if (!mask_d[k]) data_d[2*k +: 2] = DEFAULT_BALLOT;
          end
          timeout_flag_d = 1'b1;
          state_d        = EMIT;
`endif
        end
      end
      EMIT: begin
        if (frame_ready) begin
          state_d        = COLLECT;
          data_d         = '0;
          mask_d         = '0;
          timeout_flag_d = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == COLLECT);
    frame_valid  = (state_q == EMIT);
    frame_data   = data_q;
    frame_mask   = mask_q;
    dup_err      = dup_err_q;
`ifdef BALLOT_TIMEOUT_EN
    timeout_flag = timeout_flag_q;
`else
    timeout_flag = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed self-checking bench for ballot_collector; timeout cases run when BALLOT_TIMEOUT_EN is defined.
module tb_ballot_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_voter = 2'd0;
  logic [1:0] in_ballot = 2'd0;
  logic       frame_valid;
  logic       frame_ready = 1'b1;
  logic [7:0] frame_data;
  logic [3:0] frame_mask;
  logic       dup_err;
  logic       timeout_flag;

  int passes = 0;
  int total  = 0;

  ballot_collector #(
    .TIMEOUT_CYCLES(4),
    .DEFAULT_BALLOT(2'b00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_voter     (in_voter),
    .in_ballot    (in_ballot),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .frame_mask   (frame_mask),
    .dup_err      (dup_err),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] voter, input logic [1:0] ballot);
    in_valid  = 1'b1;
    in_voter  = voter;
    in_ballot = ballot;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},     in_ready,     1'b1);
    check({tag, "_frame_valid"},  frame_valid,  1'b0);
    check({tag, "_frame_data"},   frame_data,   8'h00);
    check({tag, "_frame_mask"},   frame_mask,   4'h0);
    check({tag, "_dup_err"},      dup_err,      1'b0);
    check({tag, "_timeout_flag"}, timeout_flag, 1'b0);
  endtask

  initial begin
    // Reset state
    step();
    rst = 1'b0;
    check_reset("rst0");

    // Full round, back-to-back consume
    send(2'd0, 2'b11);
    send(2'd1, 2'b01);
    send(2'd2, 2'b11);
    check("r1_not_yet_valid", frame_valid, 1'b0);
    send(2'd3, 2'b10);
    check("r1_valid",    frame_valid, 1'b1);
    check("r1_in_ready", in_ready,    1'b0);
    check("r1_data",     frame_data,  8'b10_11_01_11);
    check("r1_mask",     frame_mask,  4'hF);
    check("r1_tflag",    timeout_flag, 1'b0);
    step();
    check("r1_ready_back", in_ready,    1'b1);
    check("r1_valid_drop", frame_valid, 1'b0);
    check("r1_data_clr",   frame_data,  8'h00);
    check("r1_mask_clr",   frame_mask,  4'h0);

    // Duplicate from voter 2, then stall in EMIT with a pending ballot
    frame_ready = 1'b0;
    send(2'd2, 2'b01);
    check("dup_none_first", dup_err, 1'b0);
    send(2'd2, 2'b11);
    check("dup_pulse", dup_err,    1'b1);
    check("dup_mask",  frame_mask, 4'b0100);
    send(2'd0, 2'b00);
    check("dup_one_cycle", dup_err, 1'b0);
    send(2'd1, 2'b01);
    send(2'd3, 2'b10);
    check("dup_valid", frame_valid, 1'b1);
    check("dup_data",  frame_data,  8'b10_01_01_00);
    check("dup_mask_full", frame_mask, 4'hF);
    in_valid  = 1'b1;
    in_voter  = 2'd1;
    in_ballot = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_in_ready", in_ready,    1'b0);
      check("stall_valid",    frame_valid, 1'b1);
      check("stall_data",     frame_data,  8'b10_01_01_00);
    end
    frame_ready = 1'b1;
    step();
    check("stall_release_ready", in_ready,   1'b1);
    check("stall_release_mask",  frame_mask, 4'h0);
    step();
    in_valid = 1'b0;
    check("pending_mask", frame_mask, 4'b0010);
    check("pending_data", frame_data, 8'b00_00_11_00);

    // Reset mid-round with two ballots in
    send(2'd0, 2'b01);
    check("mid_mask", frame_mask, 4'b0011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rst_mid");

    // Reset during EMIT
    frame_ready = 1'b0;
    send(2'd0, 2'b01);
    send(2'd1, 2'b10);
    send(2'd2, 2'b00);
    send(2'd3, 2'b11);
    check("pre_rst_data", frame_data, 8'b11_00_10_01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rst_emit");

    // Fresh round in a different voter order
    send(2'd3, 2'b01);
    send(2'd2, 2'b10);
    send(2'd1, 2'b11);
    send(2'd0, 2'b00);
    check("fresh_valid", frame_valid, 1'b1);
    check("fresh_data",  frame_data,  8'b01_10_11_00);
    check("fresh_mask",  frame_mask,  4'hF);
    frame_ready = 1'b1;
    step();
    check("fresh_consumed", frame_valid, 1'b0);

`ifdef BALLOT_TIMEOUT_EN
    // Partial round: only voters 0 and 3 vote, frame forced out 4 cycles after first accept
    send(2'd0, 2'b11);
    send(2'd3, 2'b11);
    step();
    check("to_wait1", frame_valid, 1'b0);
    step();
    check("to_wait2", frame_valid, 1'b0);
    step();
    check("to_valid", frame_valid,  1'b1);
    check("to_data",  frame_data,   8'b11_00_00_11);
    check("to_mask",  frame_mask,   4'b1001);
    check("to_flag",  timeout_flag, 1'b1);
    step();
    check("to_flag_clr", timeout_flag, 1'b0);
    check("to_ready",    in_ready,     1'b1);

    // Fourth distinct ballot lands on the timeout edge: full frame wins
    send(2'd0, 2'b01);
    send(2'd1, 2'b10);
    send(2'd2, 2'b11);
    step();
    check("tie_wait", frame_valid, 1'b0);
    send(2'd3, 2'b01);
    check("tie_valid", frame_valid,  1'b1);
    check("tie_data",  frame_data,   8'b01_11_10_01);
    check("tie_mask",  frame_mask,   4'hF);
    check("tie_flag",  timeout_flag, 1'b0);
    step();
`else
    // Without the timeout build a partial round waits indefinitely
    send(2'd0, 2'b11);
    send(2'd3, 2'b11);
    for (int i = 0; i < 8; i++) step();
    check("idle_no_emit",  frame_valid,  1'b0);
    check("idle_no_flag",  timeout_flag, 1'b0);
    check("idle_mask",     frame_mask,   4'b1001);
    send(2'd1, 2'b00);
    send(2'd2, 2'b01);
    check("idle_done_data", frame_data, 8'b11_01_00_11);
    step();
`endif
    check("final_ready", in_ready, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
